alu_operand_issue: RTL and testbench
====================================

// Module: alu_operand_issue
// PURPOSE
//  EX-entry pipeline register directly upstream of the ALU. Accepts decoded ops from ID over valid/ready.
//  Selects the operands (reg/imm/pc) and resolves RAW hazards by forwarding or stalling.
//  Drives alucontrol/aluneg/D1/D2 to the ALU from registered state.
//  Also holds rd/wen/is_load and store data for the MEM stage.
// PARAMETERS
//  XLEN      32  datapath width; the ALU is fixed at 32
//  CNT_W     16  width of stall_cnt performance counter
// PORTS
//  clk            in   1     core clock, all state rising-edge
//  rst            in   1     synchronous, active-high reset
//  flush          in   1     kill held op and any op being accepted this cycle
//  dec_valid      in   1     ID offers an op
//  dec_ready      out  1     this block accepts the op this cycle
//  dec_alucontrol in   10    ALU control word, passed through unchanged
//  dec_aluneg     in   1     sub / arithmetic-shift select
//  dec_rs1,dec_rs2 in  5     source register indices
//  dec_use_rs1,dec_use_rs2 in 1  the op actually reads rs1/rs2
//  dec_rs1_data,dec_rs2_data in XLEN  regfile read data (old value on read-during-write)
//  dec_imm        in   XLEN  sign-extended immediate
//  dec_pc         in   XLEN  pc of op
//  dec_src2_imm   in   1     D2 = imm, else rs2 value
//  dec_src1_pc    in   1     D1 = pc, else rs1 value
//  dec_rd         in   5     dest index;  dec_wen in 1 writes rd;  dec_is_load in 1
//  ex_valid       out  1     held op is valid (ALU inputs meaningful)
//  ex_ready       in   1     EX/MEM accepts held op this cycle
//  alucontrol     out  10   ;  aluneg out 1 ;  D1,D2 out XLEN  to ALU
//  ex_store_data  out  XLEN  forwarded rs2 value (store data)
//  ex_rd out 5 ; ex_wen out 1 ; ex_is_load out 1
//  alu_result     in   XLEN  combinational ALU output for the held op
//  mem_valid,mem_wen in 1 ; mem_rd in 5 ; mem_data in XLEN ; mem_data_ok in 1  (0 = load still pending)
//  wb_valid,wb_wen  in 1 ; wb_rd  in 5 ; wb_data  in XLEN
//  stall_cnt      out  CNT_W cycles with dec_valid=1 and hazard=1, saturating
// BEHAVIOUR
//  Reset: ex_valid=0, all payload outputs 0, stall_cnt=0. dec_ready is combinational and 0 while rst=1.
//  Match(src,r): src_valid & src_wen & src_rd!=0 & src_rd==r. Only counted for rs with dec_use_rsN=1.
//  x0 reads give 0, never forwarded, never hazard.
//  Forward priority per operand: EX (held op: ex_valid/ex_wen/ex_rd, value alu_result) > MEM > WB > regfile.
//  hazard = EX match with ex_is_load=1, or MEM match with mem_data_ok=0.
//  dec_ready = !rst & !hazard & (!ex_valid | ex_ready).
//  Accept (dec_valid&dec_ready): next cycle ex_valid=1 with operands resolved at accept time.
//    D1 = dec_src1_pc ? pc : fwd(rs1).  D2 = dec_src2_imm ? imm : fwd(rs2).  ex_store_data = fwd(rs2).
//  ex_ready=1 & no accept: ex_valid->0 (bubble).  ex_ready=0: all outputs hold.
//  Hazard with ex_ready=1: the bubble drains the load to MEM and the stall resolves when mem_data_ok rises.
//  Latency: 1 cycle accept->ex_valid. Full throughput is one op/cycle without hazards.
//  flush=1: ex_valid->0 next cycle regardless of accept or ex_ready. Flush beats accept.
//    Payload may update but ex_valid=0. A flushed op is not counted as a stall.
//  Payload regs load only on accept. With ex_valid=0 the D1/D2 values are don't-care for checks.
//  stall_cnt +1 each cycle dec_valid & hazard & !flush. Holds at 2^CNT_W-1.
// CONFIGURATION
//  FWD_BYPASS_EN defined: forwarding as above.
//  Undefined: no bypass mux, operands come from regfile only.
//    hazard = any EX, MEM or WB match (any type).
//    Hence a back-to-back dependent op stalls 3 cycles with ex_ready=1 and mem_data_ok=1.
// TESTING
//  Reset held 2 cycles, dec_valid=1 -> dec_ready=0, ex_valid=0, stall_cnt=0.
//  ADD x1 then ADD x2,x1,x1, alu_result=5 -> second op D1=D2=5, no stall (bypass on).
//  LW x3 in EX (ex_is_load=1), dependent op offered -> 1 bubble, stall_cnt=1, then MEM fwd with mem_data_ok=1.
//  rd=x0 producer matches rs1=0 -> D1=0, no stall.
//  ex_ready=0 for 4 cycles, flush on cycle 3 -> outputs stable, then ex_valid=0 after flush.
//  Bypass off, dependent pair -> 3 stall cycles, D1 = regfile value after WB retires.

Source files
------------

// File: rtl/alu_operand_issue.sv
// EX-entry pipeline register feeding the ALU: operand select, RAW forwarding/stall,
// and MEM-stage sideband (rd/wen/is_load/store data).
// Optional feature: define FWD_BYPASS_EN to enable the EX/MEM/WB bypass network;
// when undefined, operands come from the regfile only and any in-flight match stalls.
module alu_operand_issue #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             dec_valid,
   output logic             dec_ready,
   input  logic [9:0]       dec_alucontrol,
   input  logic             dec_aluneg,
   input  logic [4:0]       dec_rs1,
   input  logic [4:0]       dec_rs2,
   input  logic             dec_use_rs1,
   input  logic             dec_use_rs2,
   input  logic [XLEN-1:0]  dec_rs1_data,
   input  logic [XLEN-1:0]  dec_rs2_data,
   input  logic [XLEN-1:0]  dec_imm,
   input  logic [XLEN-1:0]  dec_pc,
   input  logic             dec_src2_imm,
   input  logic             dec_src1_pc,
   input  logic [4:0]       dec_rd,
   input  logic             dec_wen,
   input  logic             dec_is_load,
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic [9:0]       alucontrol,
   output logic             aluneg,
   output logic [XLEN-1:0]  D1,
   output logic [XLEN-1:0]  D2,
   output logic [XLEN-1:0]  ex_store_data,
   output logic [4:0]       ex_rd,
   output logic             ex_wen,
   output logic             ex_is_load,
   input  logic [XLEN-1:0]  alu_result,
   input  logic             mem_valid,
   input  logic             mem_wen,
   input  logic [4:0]       mem_rd,
   input  logic [XLEN-1:0]  mem_data,
   input  logic             mem_data_ok,
   input  logic             wb_valid,
   input  logic             wb_wen,
   input  logic [4:0]       wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // A producer stage writes register rs (x0 never matches).
   function automatic logic hit(input logic v, input logic w, input logic [4:0] rd,
                                input logic [4:0] rs);
      return v & w & (rd != 5'd0) & (rd == rs);
   endfunction

   logic            ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
   logic            hazard;
   logic            accept;
   logic [XLEN-1:0] op1_val, op2_val;

   assign ex_m1  = dec_use_rs1 & hit(ex_valid,  ex_wen,  ex_rd,  dec_rs1);
   assign ex_m2  = dec_use_rs2 & hit(ex_valid,  ex_wen,  ex_rd,  dec_rs2);
   assign mem_m1 = dec_use_rs1 & hit(mem_valid, mem_wen, mem_rd, dec_rs1);
   assign mem_m2 = dec_use_rs2 & hit(mem_valid, mem_wen, mem_rd, dec_rs2);
   assign wb_m1  = dec_use_rs1 & hit(wb_valid,  wb_wen,  wb_rd,  dec_rs1);
   assign wb_m2  = dec_use_rs2 & hit(wb_valid,  wb_wen,  wb_rd,  dec_rs2);

`ifdef FWD_BYPASS_EN
   // Only an unresolved load (in EX, or pending in MEM) blocks issue.
   assign hazard = ((ex_m1 | ex_m2) & ex_is_load) | ((mem_m1 | mem_m2) & ~mem_data_ok);

   // Bypass mux, youngest producer first; x0 always reads zero.
   always_comb begin
      op1_val = dec_rs1_data;
      op2_val = dec_rs2_data;
      if (dec_rs1 == 5'd0) op1_val = '0;
      else if (ex_m1)      op1_val = alu_result;
      else if (mem_m1)     op1_val = mem_data;
      else if (wb_m1)      op1_val = wb_data;
      if (dec_rs2 == 5'd0) op2_val = '0;
      else if (ex_m2)      op2_val = alu_result;
      else if (mem_m2)     op2_val = mem_data;
      else if (wb_m2)      op2_val = wb_data;
   end
`else
   // Without bypass, any in-flight writer of a source register blocks issue.
   assign hazard = ex_m1 | ex_m2 | mem_m1 | mem_m2 | wb_m1 | wb_m2;

   logic unused_fwd;
   assign unused_fwd = ^{alu_result, mem_data, mem_data_ok, wb_data};

   // Regfile operands only; x0 always reads zero.
   always_comb begin
      op1_val = (dec_rs1 == 5'd0) ? '0 : dec_rs1_data;
      op2_val = (dec_rs2 == 5'd0) ? '0 : dec_rs2_data;
   end
`endif

   assign dec_ready = ~rst & ~hazard & (~ex_valid | ex_ready);
   assign accept    = dec_valid & dec_ready;

   // Held op register, valid bit and saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         alucontrol    <= '0;
         aluneg        <= 1'b0;
         D1            <= '0;
         D2            <= '0;
         ex_store_data <= '0;
         ex_rd         <= '0;
         ex_wen        <= 1'b0;
         ex_is_load    <= 1'b0;
         stall_cnt     <= '0;
      end else begin
         if (accept) begin
            alucontrol    <= dec_alucontrol;
            aluneg        <= dec_aluneg;
            D1            <= dec_src1_pc  ? dec_pc  : op1_val;
            D2            <= dec_src2_imm ? dec_imm : op2_val;
            ex_store_data <= op2_val;
            ex_rd         <= dec_rd;
            ex_wen        <= dec_wen;
            ex_is_load    <= dec_is_load;
         end
         if (flush)         ex_valid <= 1'b0;
         else if (accept)   ex_valid <= 1'b1;
         else if (ex_ready) ex_valid <= 1'b0;
         if (dec_valid & hazard & ~flush & (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed testbench for alu_operand_issue; follows FWD_BYPASS_EN like the RTL build.
module tb_alu_operand_issue;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst, flush, dec_valid, dec_ready;
   logic [9:0]       dec_alucontrol;
   logic             dec_aluneg;
   logic [4:0]       dec_rs1, dec_rs2, dec_rd;
   logic             dec_use_rs1, dec_use_rs2;
   logic [XLEN-1:0]  dec_rs1_data, dec_rs2_data, dec_imm, dec_pc;
   logic             dec_src2_imm, dec_src1_pc, dec_wen, dec_is_load;
   logic             ex_valid, ex_ready;
   logic [9:0]       alucontrol;
   logic             aluneg;
   logic [XLEN-1:0]  D1, D2, ex_store_data;
   logic [4:0]       ex_rd;
   logic             ex_wen, ex_is_load;
   logic [XLEN-1:0]  alu_result;
   logic             mem_valid, mem_wen, mem_data_ok;
   logic [4:0]       mem_rd;
   logic [XLEN-1:0]  mem_data;
   logic             wb_valid, wb_wen;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic [CNT_W-1:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_stall = 0;

   alu_operand_issue #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_alucontrol(dec_alucontrol), .dec_aluneg(dec_aluneg),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
      .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
      .dec_imm(dec_imm), .dec_pc(dec_pc),
      .dec_src2_imm(dec_src2_imm), .dec_src1_pc(dec_src1_pc),
      .dec_rd(dec_rd), .dec_wen(dec_wen), .dec_is_load(dec_is_load),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .alucontrol(alucontrol), .aluneg(aluneg), .D1(D1), .D2(D2),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_wen(ex_wen),
      .ex_is_load(ex_is_load), .alu_result(alu_result),
      .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd),
      .mem_data(mem_data), .mem_data_ok(mem_data_ok),
      .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if it mismatches.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Present a register-register op; selects and immediates reset to defaults.
   task automatic set_op(input logic [4:0] rs1, input logic [XLEN-1:0] v1,
                         input logic [4:0] rs2, input logic [XLEN-1:0] v2,
                         input logic [4:0] rd, input logic wen, input logic ld);
      dec_rs1 = rs1;  dec_rs1_data = v1;  dec_use_rs1 = 1'b1;
      dec_rs2 = rs2;  dec_rs2_data = v2;  dec_use_rs2 = 1'b1;
      dec_rd = rd;    dec_wen = wen;      dec_is_load = ld;
      dec_src1_pc = 1'b0; dec_src2_imm = 1'b0;
      dec_imm = '0;   dec_pc = '0;
   endtask

   task automatic clr_mem_wb();
      mem_valid = 1'b0; mem_wen = 1'b0; mem_rd = '0; mem_data = '0; mem_data_ok = 1'b1;
      wb_valid = 1'b0;  wb_wen = 1'b0;  wb_rd = '0;  wb_data = '0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; dec_valid = 1'b1; ex_ready = 1'b1;
      dec_alucontrol = '0; dec_aluneg = 1'b0; alu_result = '0;
      set_op(5'd0, '0, 5'd0, '0, 5'd0, 1'b0, 1'b0);
      clr_mem_wb();

      // Reset held two cycles with an op offered.
      tick(); tick();
      check("rst_dec_ready", 64'(dec_ready), 64'd0);
      check("rst_ex_valid",  64'(ex_valid),  64'd0);
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      check("rst_D1",        64'(D1),        64'd0);
      check("rst_ex_rd",     64'(ex_rd),     64'd0);

      // ADD x1 = x5 + x6
      rst = 1'b0;
      set_op(5'd5, 32'd2, 5'd6, 32'd3, 5'd1, 1'b1, 1'b0);
      dec_alucontrol = 10'h155; dec_aluneg = 1'b1;
      settle();
      check("op1_dec_ready", 64'(dec_ready), 64'd1);
      tick();
      check("op1_ex_valid",   64'(ex_valid),   64'd1);
      check("op1_D1",         64'(D1),         64'd2);
      check("op1_D2",         64'(D2),         64'd3);
      check("op1_alucontrol", 64'(alucontrol), 64'h155);
      check("op1_aluneg",     64'(aluneg),     64'd1);
      check("op1_ex_rd",      64'(ex_rd),      64'd1);
      check("op1_ex_wen",     64'(ex_wen),     64'd1);

      // ADD x2 = x1 + x1 while x1's producer is in EX (regfile still stale).
      set_op(5'd1, 32'd99, 5'd1, 32'd99, 5'd2, 1'b1, 1'b0);
      dec_alucontrol = 10'h02a; dec_aluneg = 1'b0;
      alu_result = 32'd5;
`ifdef FWD_BYPASS_EN
      settle();
      check("dep_ready_fwd", 64'(dec_ready), 64'd1);
      tick();
      check("dep_D1_fwd",    64'(D1),            64'd5);
      check("dep_D2_fwd",    64'(D2),            64'd5);
      check("dep_store_fwd", 64'(ex_store_data), 64'd5);
      check("dep_no_stall",  64'(stall_cnt),     64'(exp_stall));

      // LW x3, 8(x5)
      set_op(5'd5, 32'd100, 5'd0, '0, 5'd3, 1'b1, 1'b1);
      dec_use_rs2 = 1'b0; dec_src2_imm = 1'b1; dec_imm = 32'd8;
      tick();
      check("lw_D1",      64'(D1),         64'd100);
      check("lw_D2_imm",  64'(D2),         64'd8);
      check("lw_is_load", 64'(ex_is_load), 64'd1);

      // Consumer of x3: one bubble while the load moves to MEM.
      set_op(5'd3, 32'd0, 5'd0, '0, 5'd4, 1'b1, 1'b0);
      dec_use_rs2 = 1'b0;
      settle();
      check("ld_use_ready", 64'(dec_ready), 64'd0);
      tick();
      exp_stall = exp_stall + 1;
      check("ld_use_bubble", 64'(ex_valid),  64'd0);
      check("ld_use_stall",  64'(stall_cnt), 64'(exp_stall));
      mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 5'd3; mem_data = 32'd77; mem_data_ok = 1'b1;
      settle();
      check("ld_mem_ready", 64'(dec_ready), 64'd1);
      tick();
      check("ld_mem_D1",    64'(D1),        64'd77);
      check("ld_mem_valid", 64'(ex_valid),  64'd1);
      check("ld_mem_stall", 64'(stall_cnt), 64'(exp_stall));
      clr_mem_wb();
`else
      // Producer walks EX -> MEM -> WB; consumer stalls in each.
      settle();
      check("nb_ready_ex", 64'(dec_ready), 64'd0);
      tick();
      exp_stall = exp_stall + 1;
      check("nb_bubble", 64'(ex_valid), 64'd0);
      mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 5'd1; mem_data = 32'd5; mem_data_ok = 1'b1;
      settle();
      check("nb_ready_mem", 64'(dec_ready), 64'd0);
      tick();
      exp_stall = exp_stall + 1;
      clr_mem_wb();
      wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
      settle();
      check("nb_ready_wb", 64'(dec_ready), 64'd0);
      tick();
      exp_stall = exp_stall + 1;
      clr_mem_wb();
      dec_rs1_data = 32'd5; dec_rs2_data = 32'd5;
      settle();
      check("nb_ready_free", 64'(dec_ready), 64'd1);
      tick();
      check("nb_D1",    64'(D1),        64'd5);
      check("nb_D2",    64'(D2),        64'd5);
      check("nb_valid", 64'(ex_valid),  64'd1);
      check("nb_stall", 64'(stall_cnt), 64'd3);
`endif

      // Producer writing x0 (D1 from pc), then a consumer of x0.
      set_op(5'd7, 32'd1, 5'd8, 32'd2, 5'd0, 1'b1, 1'b0);
      dec_src1_pc = 1'b1; dec_pc = 32'h1000;
      tick();
      check("x0p_D1_pc", 64'(D1),    64'h1000);
      check("x0p_ex_rd", 64'(ex_rd), 64'd0);
      set_op(5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 1'b1, 1'b0);
      alu_result = 32'd55;
      settle();
      check("x0c_ready", 64'(dec_ready), 64'd1);
      tick();
      check("x0c_D1",    64'(D1),        64'd0);
      check("x0c_D2",    64'(D2),        64'd0);
      check("x0c_stall", 64'(stall_cnt), 64'(exp_stall));

      // Load a recognisable op, then backpressure four cycles with flush on the third.
      set_op(5'd10, 32'hdeadbeef, 5'd11, 32'd1234, 5'd6, 1'b1, 1'b0);
      tick();
      check("hold_load_D1", 64'(D1), 64'hdeadbeef);
      ex_ready = 1'b0;
      set_op(5'd12, 32'd7, 5'd13, 32'd8, 5'd7, 1'b1, 1'b0);
      settle();
      check("hold_ready", 64'(dec_ready), 64'd0);
      for (int c = 1; c <= 2; c++) begin
         tick();
         check("hold_valid", 64'(ex_valid), 64'd1);
         check("hold_D1",    64'(D1),       64'hdeadbeef);
         check("hold_D2",    64'(D2),       64'd1234);
         check("hold_rd",    64'(ex_rd),    64'd6);
      end
      flush = 1'b1;
      tick();
      check("flush_valid", 64'(ex_valid), 64'd0);
      check("flush_D1",    64'(D1),       64'hdeadbeef);
      flush = 1'b0; dec_valid = 1'b0;
      tick();
      check("post_flush_valid", 64'(ex_valid), 64'd0);

      // Flush beats a same-cycle accept.
      ex_ready = 1'b1; dec_valid = 1'b1; flush = 1'b1;
      settle();
      check("fa_ready", 64'(dec_ready), 64'd1);
      tick();
      check("fa_valid", 64'(ex_valid), 64'd0);

      // Hazard on a pending MEM load: not counted while flushing, counted otherwise.
      set_op(5'd9, 32'd0, 5'd0, 32'd0, 5'd8, 1'b1, 1'b0);
      mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 5'd9; mem_data_ok = 1'b0;
      settle();
      check("hz_ready", 64'(dec_ready), 64'd0);
      tick();
      check("hz_flush_stall", 64'(stall_cnt), 64'(exp_stall));
      flush = 1'b0;
      tick();
      exp_stall = exp_stall + 1;
      check("hz_stall", 64'(stall_cnt), 64'(exp_stall));

      // Same match but the op does not read rs1: no hazard.
      dec_use_rs1 = 1'b0;
      settle();
      check("unused_rs_ready", 64'(dec_ready), 64'd1);
      tick();
      check("unused_rs_valid", 64'(ex_valid),  64'd1);
      check("unused_rs_stall", 64'(stall_cnt), 64'(exp_stall));

      // Hazard with nothing offered is not a stall; held op drains.
      dec_use_rs1 = 1'b1; dec_valid = 1'b0;
      tick();
      check("idle_hz_stall", 64'(stall_cnt), 64'(exp_stall));
      check("idle_drain",    64'(ex_valid),  64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
